// File: rtl/poly_key_synth_pkg.sv
// Shared types, pitch table and width helpers for the polyphonic key synthesiser.
package poly_key_synth_pkg;

  typedef enum logic {VoiceIdle, VoicePlay} voice_state_e;

  // Half-period dividers for one octave starting at C3, for a 10 MHz clock.
  localparam logic [15:0] NOTE_DIV [12] = '{
    16'd38223, 16'd36077, 16'd34052, 16'd32141, 16'd30337, 16'd28635,
    16'd27027, 16'd25511, 16'd24079, 16'd22727, 16'd21452, 16'd20248
  };

  // Width of an index into n items, never zero.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a count that can reach n.
  function automatic int unsigned mix_w(int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Half-period for a key at a given octave shift; very high notes clamp to 2.
  function automatic logic [15:0] calc_div(int unsigned key, int unsigned oct);
    logic [15:0] d;
    d = NOTE_DIV[4'(key % 12)] >> (oct + key / 12);
    if (d < 16'd2) d = 16'd2;
    return d;
  endfunction

endpackage

// File: rtl/poly_key_synth_if.sv
// Key/octave/enable inputs and voice/mix/audio outputs of the synthesiser.
interface poly_key_synth_if import poly_key_synth_pkg::*; #(
  parameter int unsigned NUM_KEYS   = 12,
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned OCT_W      = 3
);
  logic                           ena;
  logic [NUM_KEYS-1:0]            keys;
  logic [OCT_W-1:0]               octave;
  logic [NUM_VOICES-1:0]          voice_active;
  logic [mix_w(NUM_VOICES)-1:0]   mix;
  logic                           pdm_out;
  logic                           overflow;

  modport master (
    output ena, keys, octave,
    input  voice_active, mix, pdm_out, overflow
  );

  modport slave (
    input  ena, keys, octave,
    output voice_active, mix, pdm_out, overflow
  );
endinterface

// File: rtl/poly_key_synth_voice.sv
// One square-wave voice: holds its key and divider while playing, toggles every div cycles.
module poly_key_synth_voice import poly_key_synth_pkg::*; #(
  parameter int unsigned NUM_KEYS = 12,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned KEY_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                start,
  input  logic [KEY_W-1:0]    start_key,
  input  logic [DIV_W-1:0]    start_div,
  input  logic [NUM_KEYS-1:0] key_level,
  output logic                play,
  output logic                square
);

  voice_state_e     state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sq_q, sq_d;

  // Voice state, stored key/divider and tone counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= VoiceIdle;
      key_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      sq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      sq_q    <= sq_d;
    end
  end

  // Allocation, release and half-period counting.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    sq_d    = sq_q;
    unique case (state_q)
      VoiceIdle: begin
        cnt_d = '0;
        sq_d  = 1'b0;
        if (ena && start) begin
          state_d = VoicePlay;
          key_d   = start_key;
          div_d   = start_div;
        end
      end
      VoicePlay: begin
        if (!ena) begin
          state_d = VoiceIdle;
          cnt_d   = '0;
          sq_d    = 1'b0;
        end else if (start) begin
          // Stolen while playing: restart on the new note.
          key_d = start_key;
          div_d = start_div;
          cnt_d = '0;
          sq_d  = 1'b0;
        end else if (!key_level[key_q]) begin
          state_d = VoiceIdle;
          cnt_d   = '0;
          sq_d    = 1'b0;
        end else if (cnt_q == div_q - DIV_W'(1)) begin
          cnt_d = '0;
          sq_d  = ~sq_q;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = VoiceIdle;
    endcase
  end

  assign play   = (state_q == VoicePlay);
  assign square = sq_q;

endmodule

// File: rtl/poly_key_synth.sv
// Polyphonic key synthesiser: synchronises keys, allocates presses to square-wave voices,
// and produces a registered voice count plus a first-order PDM stream.
// Define POLY_KEY_SYNTH_VOICE_STEAL_EN to steal the oldest voice instead of dropping a press.
module poly_key_synth import poly_key_synth_pkg::*; #(
  parameter int unsigned NUM_KEYS    = 12,
  parameter int unsigned NUM_VOICES  = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned OCT_W       = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             rst,
  poly_key_synth_if.slave bus
);

  localparam int unsigned KEY_W   = idx_w(NUM_KEYS);
  localparam int unsigned VOICE_W = idx_w(NUM_VOICES);
  localparam int unsigned MIX_W   = mix_w(NUM_VOICES);
  localparam int unsigned ACC_W   = $clog2(2 * NUM_VOICES);

  logic [SYNC_STAGES-1:0][NUM_KEYS-1:0] sync_q;
  logic [NUM_KEYS-1:0]   prev_q, synced, rise, cand, key_onehot;
  logic [NUM_KEYS-1:0]   pending_q, pending_d;
  logic                  have_key, have_voice, drop;
  logic [KEY_W-1:0]      key_sel;
  logic [VOICE_W-1:0]    voice_sel;
  logic [DIV_W-1:0]      alloc_div;
  logic [NUM_VOICES-1:0] start, playing, square;
  logic [NUM_VOICES-1:0] va_q;
  logic [MIX_W-1:0]      mix_q, mix_d;
  logic [ACC_W-1:0]      acc_q, acc_next;
  logic                  pdm_q, ovf_q;

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~prev_q;
  // A pending press whose key already fell is no longer a candidate.
  assign cand   = pending_q & synced;

  // Key synchroniser chain and previous-level register; never cleared by ena.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.keys};
      prev_q <= synced;
    end
  end

  // Pick the lowest pending key and the lowest idle voice.
  always_comb begin
    have_key   = 1'b0;
    key_sel    = '0;
    key_onehot = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (cand[k]) begin
        have_key   = 1'b1;
        key_sel    = KEY_W'(k);
        key_onehot = '0;
        key_onehot[k] = 1'b1;
      end
    end
    have_voice = 1'b0;
    voice_sel  = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!playing[v]) begin
        have_voice = 1'b1;
        voice_sel  = VOICE_W'(v);
      end
    end
  end

`ifdef POLY_KEY_SYNTH_VOICE_STEAL_EN
  logic [7:0]         seq_q;
  logic [7:0]         vseq_q [NUM_VOICES];
  logic [7:0]         age, best;
  logic [VOICE_W-1:0] oldest_sel;

  // Oldest voice by allocation age modulo 256; ties go to the lower index.
  always_comb begin
    best       = seq_q - vseq_q[0];
    oldest_sel = '0;
    age        = '0;
    for (int v = 1; v < NUM_VOICES; v++) begin
      age = seq_q - vseq_q[v];
      if (age > best) begin
        best       = age;
        oldest_sel = VOICE_W'(v);
      end
    end
  end

  // Global allocation sequence and per-voice allocation stamp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q  <= '0;
      vseq_q <= '{default: '0};
    end else if (|start) begin
      seq_q <= seq_q + 8'd1;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (start[v]) vseq_q[v] <= seq_q;
      end
    end
  end
`endif

  // At most one allocation per cycle; without a free voice the press overflows.
  always_comb begin
    start = '0;
    drop  = 1'b0;
    if (bus.ena && have_key) begin
      if (have_voice) begin
        start[voice_sel] = 1'b1;
      end else begin
        drop = 1'b1;
`ifdef POLY_KEY_SYNTH_VOICE_STEAL_EN
        start[oldest_sel] = 1'b1;
`endif
      end
    end
    pending_d = bus.ena ? ((cand & ~key_onehot) | rise) : '0;
  end

  assign alloc_div = DIV_W'(calc_div(32'(key_sel), 32'(bus.octave)));

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    poly_key_synth_voice #(
      .NUM_KEYS (NUM_KEYS),
      .DIV_W    (DIV_W),
      .KEY_W    (KEY_W)
    ) u_voice (
      .clk       (clk),
      .rst       (rst),
      .ena       (bus.ena),
      .start     (start[v]),
      .start_key (key_sel),
      .start_div (alloc_div),
      .key_level (prev_q),
      .play      (playing[v]),
      .square    (square[v])
    );
  end

  // Count of voices whose square output is high.
  always_comb begin
    mix_d = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      mix_d = mix_d + MIX_W'(square[v]);
    end
    acc_next = acc_q + ACC_W'(mix_q);
  end

  // Registered outputs, pending mask and sigma-delta accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      va_q      <= '0;
      mix_q     <= '0;
      acc_q     <= '0;
      pdm_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= drop;
      if (!bus.ena) begin
        va_q  <= '0;
        mix_q <= '0;
        acc_q <= '0;
        pdm_q <= 1'b0;
      end else begin
        va_q  <= playing;
        mix_q <= mix_d;
        if (acc_next >= ACC_W'(NUM_VOICES)) begin
          pdm_q <= 1'b1;
          acc_q <= acc_next - ACC_W'(NUM_VOICES);
        end else begin
          pdm_q <= 1'b0;
          acc_q <= acc_next;
        end
      end
    end
  end

  assign bus.voice_active = va_q;
  assign bus.mix          = mix_q;
  assign bus.pdm_out      = pdm_q;
  assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_poly_key_synth.sv
// Randomised bench for poly_key_synth with a cycle-level reference model and scoreboard.
module tb_poly_key_synth;

  localparam int unsigned NK = 12;
  localparam int unsigned NV = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned OW = 3;
  localparam int unsigned SS = 2;
  localparam int unsigned MW = $clog2(NV + 1);

  typedef struct packed {
    logic [NV-1:0] va;
    logic [MW-1:0] mix;
    logic          pdm;
    logic          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  poly_key_synth_if #(.NUM_KEYS(NK), .NUM_VOICES(NV), .OCT_W(OW)) bus ();

  poly_key_synth #(
    .NUM_KEYS    (NK),
    .NUM_VOICES  (NV),
    .DIV_W       (DW),
    .OCT_W       (OW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  const int note_tab [12] = '{38223, 36077, 34052, 32141, 30337, 28635,
                              27027, 25511, 24079, 22727, 21452, 20248};

  exp_t          exp_q [$];
  int            n_cmp = 0;
  int            n_bad = 0;
  bit            done  = 1'b0;

  // Reference model state.
  logic [NK-1:0] kq [$];
  logic [NK-1:0] pend;
  bit            m_play  [NV];
  int            m_key   [NV];
  int            m_div   [NV];
  int            m_phase [NV];
  int            m_seq   [NV];
  int            seq_now;
  int            m_acc;
  exp_t          cur;

  function automatic int exp_div(int k, int oct);
    int d;
    d = note_tab[k % 12] >> (oct + k / 12);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic check(string nm, int act, int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, want);
    end
  endtask

  task automatic model_reset();
    kq.delete();
    for (int i = 0; i <= SS; i++) kq.push_back('0);
    pend = '0;
    for (int v = 0; v < NV; v++) begin
      m_play[v] = 1'b0; m_key[v] = 0; m_div[v] = 2; m_phase[v] = 0; m_seq[v] = 0;
    end
    seq_now = 0;
    m_acc   = 0;
    cur     = '0;
  endtask

  // One clock edge of the model, using inputs as the DUT sees them at this edge.
  task automatic model_step();
    logic [NK-1:0] synced, prevl, rise, cand;
    exp_t nxt;
    int k, grant, sq_cnt, a, best, age;
    synced = kq[SS-1];
    prevl  = kq[SS];
    nxt    = '0;
    sq_cnt = 0;
    k      = -1;
    grant  = -1;
    if (bus.ena) begin
      for (int v = 0; v < NV; v++) begin
        nxt.va[v] = m_play[v];
        if (m_play[v] && ((m_phase[v] / m_div[v]) % 2 == 1)) sq_cnt++;
      end
      nxt.mix = MW'(sq_cnt);
      rise = synced & ~prevl;
      cand = pend & synced;
      for (int i = NK - 1; i >= 0; i--) if (cand[i]) k = i;
      if (k >= 0) begin
        for (int v = NV - 1; v >= 0; v--) if (!m_play[v]) grant = v;
        if (grant < 0) begin
          nxt.ovf = 1'b1;
`ifdef POLY_KEY_SYNTH_VOICE_STEAL_EN
          best = -1;
          for (int v = 0; v < NV; v++) begin
            age = (seq_now - m_seq[v]) & 255;
            if (age > best) begin best = age; grant = v; end
          end
`endif
        end
      end
      for (int v = 0; v < NV; v++) begin
        if (v == grant) begin
          m_play[v] = 1'b1; m_key[v] = k; m_div[v] = exp_div(k, int'(bus.octave));
          m_phase[v] = 0;
        end else if (m_play[v]) begin
          if (prevl[m_key[v]]) m_phase[v]++;
          else m_play[v] = 1'b0;
        end
      end
      if (grant >= 0) begin
        m_seq[grant] = seq_now;
        seq_now = (seq_now + 1) % 256;
      end
      pend = cand | rise;
      if (k >= 0) pend[k] = 1'b0;
      a = m_acc + int'(cur.mix);
      if (a >= NV) begin nxt.pdm = 1'b1; a -= NV; end
      m_acc = a;
    end else begin
      for (int v = 0; v < NV; v++) m_play[v] = 1'b0;
      pend  = '0;
      m_acc = 0;
    end
    cur = nxt;
    exp_q.push_back(nxt);
    kq.push_front(bus.keys);
    void'(kq.pop_back());
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      model_reset();
      exp_q.push_back('0);
    end else begin
      model_step();
    end
    #2;
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  // Asynchronous reset in the middle of a cycle: outputs must drop at once.
  task automatic mid_reset();
    #1 rst = 1'b1;
    #1;
    check("rst_voice_active", int'(bus.voice_active), 0);
    check("rst_mix", int'(bus.mix), 0);
    check("rst_pdm_out", int'(bus.pdm_out), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    exp_q.delete();
    exp_q.push_back('0);
    run(3);
    rst = 1'b0;
  endtask

  // Monitor: compare every presented output cycle against the oldest expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("voice_active", int'(bus.voice_active), int'(e.va));
        check("mix", int'(bus.mix), int'(e.mix));
        check("pdm_out", int'(bus.pdm_out), int'(e.pdm));
        check("overflow", int'(bus.overflow), int'(e.ovf));
      end
    end
  end

  initial begin : stim
    int idx;
    rst = 1'b1;
    bus.ena = 1'b0;
    bus.keys = '0;
    bus.octave = '0;
    model_reset();
    run(3);
    rst = 1'b0;
    bus.ena = 1'b1;
    run(4);

    // Single note, then an octave change that must not affect it.
    bus.octave = 3'd7;
    bus.keys[9] = 1'b1;
    run(420);
    bus.octave = 3'd3;
    run(60);
    bus.keys = '0;
    run(10);

    // Chord in one cycle, release the middle note, re-press another key.
    bus.octave = 3'd6;
    bus.keys[0] = 1'b1; bus.keys[4] = 1'b1; bus.keys[7] = 1'b1;
    run(1300);
    bus.keys[4] = 1'b0;
    run(10);
    bus.keys[2] = 1'b1;
    run(30);

    // More presses than voices.
    bus.keys[1] = 1'b1; bus.keys[3] = 1'b1; bus.keys[5] = 1'b1;
    run(40);
    bus.keys = '0;
    run(10);

    // Two voices, then drop enable.
    bus.octave = 3'd7;
    bus.keys[0] = 1'b1; bus.keys[7] = 1'b1;
    run(500);
    bus.ena = 1'b0;
    run(3);
    bus.ena = 1'b1;
    run(10);
    mid_reset();
    run(5);

    // Random key activity.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(7) == 0) begin
        idx = $urandom_range(NK - 1);
        bus.keys[idx] = ~bus.keys[idx];
      end
      if ($urandom_range(99) == 0) bus.octave = OW'($urandom_range(7, 4));
      if ($urandom_range(299) == 0) bus.ena = 1'b0;
      else if (!bus.ena && $urandom_range(3) == 0) bus.ena = 1'b1;
      if (i == 1200) mid_reset();
      cycle();
    end

    // Drain outstanding expectations, bounded.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/poly_key_synth.md
Name: poly_key_synth

Overview:
Parametrised polyphonic successor to the single-note piano datapath. It takes NUM_KEYS key levels and allocates each new press to one of NUM_VOICES square-wave voices. Each voice's pitch comes from a semitone table plus octave shift. Voices are summed into a multi-bit mix and a 1-bit PDM stream for the audio pin, next to the LED/tone outputs in the top-level wrapper.

Parameters:
NUM_KEYS, 12, key inputs; multiple of 12, max 48; key k = semitone k%12, octave offset k/12
NUM_VOICES, 4, simultaneous voices, 1..8
DIV_W, 16, half-period counter width
OCT_W, 3, user octave select width
SYNC_STAGES, 2, key input synchroniser depth, >=2

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
ena  in  1  design enable; low = synchronous clear of all voices
keys  in  NUM_KEYS  raw key levels, asynchronous
octave  in  OCT_W  octave shift applied at allocation time
voice_active  out  NUM_VOICES  per-voice playing flag
mix  out  $clog2(NUM_VOICES+1)  count of voices whose square output is high
pdm_out  out  1  first-order sigma-delta of mix/NUM_VOICES
overflow  out  1  one-cycle pulse: press dropped, no free voice

Behaviour:
- Reset (async, rst=1): synchronisers, edge regs, pending mask, all voices IDLE, counters 0, accumulator 0. All outputs 0.
- Input path: keys pass through a SYNC_STAGES flop chain, then a 1-flop previous-level register. Rising edge sets pending[k]. pending[k] clears when allocated, dropped, or when the synced key falls.
- Latency: a key first sampled high at edge 0 produces voice_active high after edge SYNC_STAGES+2. Release has the same latency to voice_active low.
- Voice FSM, per voice: IDLE -> PLAY on allocation; PLAY -> IDLE when its stored key's synced level is 0, or ena=0.
- Allocation: at most one allocation per cycle.
  - Lowest-index pending key goes to the lowest-index voice that is IDLE at the start of the cycle.
  - A voice released this cycle is free next cycle.
  - If pending exists and no voice is free: overflow=1 for 1 cycle and that pending bit clears (dropped).
- Divider latched at allocation: div = NOTE_DIV[k%12] >> (octave + k/12), clamped to minimum 2. A later octave change does not affect voices already playing.
- Tone generation:
  - On allocation: counter=0, square=0.
  - Each cycle in PLAY: if counter==div-1, then counter=0 and square toggles; else counter+1.
  - Period = 2*div cycles. IDLE voice: square=0.
- mix = popcount of voice square bits, registered (1-cycle latency).
- PDM: acc_next = acc + mix. If acc_next >= NUM_VOICES, then pdm_out=1 and acc = acc_next - NUM_VOICES; else pdm_out=0 and acc = acc_next. Registered.
- Same key released and re-pressed: handled as release then new allocation (voice may differ).
- Same-key duplicate allocation is impossible: pending only sets on a rising edge.
- ena=0: voices IDLE, pending cleared, mix=0, pdm_out=0, acc=0. Synchronisers keep running.

Optional Feature:
POLY_KEY_SYNTH_VOICE_STEAL_EN.
- Defined: with no free voice, the pending press steals the oldest PLAY voice instead of being dropped. overflow still pulses 1 cycle. Age tracking:
  - An 8-bit global sequence counter increments per allocation and is stored per voice.
  - Oldest = maximal (seq_now - seq_v) mod 256; ties go to the lowest index.
  - The stolen voice restarts with counter=0, square=0 and the new key/div.
- Undefined: drop behaviour as above; no sequence registers.

Decomposition:
- Package poly_key_synth_pkg holds:
  - NOTE_DIV[12], 16-bit half-periods for 10 MHz clk, octave 0 = C3: 38223, 36077, 34052, 32141, 30337, 28635, 27027, 25511, 24079, 22727, 21452, 20248
  - localparam helpers for the key-index width and mix width
- Sub-module synth_voice: FSM, div latch, counter, square; instantiated NUM_VOICES times via generate.

Test Plan:
- Reset: assert rst mid-tone -> all outputs 0 immediately (async); after release, no voice active until a new press.
- Single note: keys[9]=1, octave=0 -> voice_active=0001 at edge SYNC_STAGES+2; voice 0 square period 45454 cycles; octave=1 gives 22726.
- Octave clamp: NUM_KEYS=12, octave=7, key 0 -> div 298, period 596; octave change mid-note leaves the period unchanged.
- Polyphony: press keys 0,4,7 in the same cycle -> voices 0,1,2 allocate on consecutive cycles in key order; mix peaks at 3; release key 4 -> voice 1 IDLE; the next press takes voice 1.
- Overflow (NUM_VOICES=4): 5th concurrent press -> overflow 1-cycle pulse, voice_active stays 1111. With the _EN macro defined: voice 0 (oldest) is reassigned to the new key.
- PDM/ena: two voices high, NUM_VOICES=4 -> pdm_out density 50% over 64 cycles; ena=0 -> voice_active=0, mix=0, pdm_out=0 next cycle.
